// File: rtl/pb_conditioner_if.sv
// Pushbutton conditioner bus: raw button lines in, debounced key events out.
interface pb_conditioner_if #(
  parameter int NKEYS = 21
);
  logic [NKEYS-1:0] pb;
  logic [4:0]       code;
  logic             strobe;
  logic             held;
  logic             step;
  logic             clr;

  modport master (output pb, input code, strobe, held, step, clr);
  modport slave  (input pb, output code, strobe, held, step, clr);
endinterface

// File: rtl/pb_conditioner.sv
// Synchronizes, debounces and priority-encodes the pushbutton bus, emitting one
// strobe per accepted press (plus optional auto-repeat) and step/clr decodes.
module pb_conditioner #(
  parameter int NKEYS     = 21,
  parameter int DEBOUNCE  = 3,
  parameter int RPT_EN    = 1,
  parameter int RPT_DELAY = 50,
  parameter int RPT_RATE  = 10
) (
  input  logic            hz100,
  input  logic            reset_n,
  pb_conditioner_if.slave bus
);

  localparam int CNT_W = (DEBOUNCE > 63) ? $clog2(DEBOUNCE + 1) : 6;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t       DEB_C        = cnt_t'(DEBOUNCE);
  localparam logic [7:0] RPT_DELAY_C  = 8'(RPT_DELAY);
  localparam logic [7:0] RPT_RELOAD_C = 8'(RPT_DELAY - RPT_RATE);

  typedef enum logic [1:0] {IDLE, ARM, PRESS, REL} state_t;

  function automatic logic [4:0] hi_index(input logic [NKEYS-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < NKEYS; i++)
      if (v[i]) idx = 5'(i);
    return idx;
  endfunction

  // Stage p0/p1: two-flop synchronizer on the raw buttons
  logic [NKEYS-1:0] pb_p0_q, pb_p1_q;

  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      pb_p0_q <= '0;
      pb_p1_q <= '0;
    end else begin
      pb_p0_q <= bus.pb;
      pb_p1_q <= pb_p0_q;
    end
  end

  logic       any;
  logic [4:0] enc;

  assign any = |pb_p1_q;
  assign enc = hi_index(pb_p1_q);

  // Stage p2: debounce/repeat state machine with registered outputs
  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [4:0] cand_q, cand_d;
  logic [7:0] rcnt_q, rcnt_d;
  logic [4:0] code_q, code_d;
  logic       strobe_q, strobe_d;
  logic       held_q, held_d;
  logic       step_q, step_d;
  logic       clr_q, clr_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    rcnt_d   = rcnt_q;
    code_d   = code_q;
    held_d   = held_q;
    strobe_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = ARM;
          cand_d  = enc;
          cnt_d   = cnt_t'(1);
        end
      end
      ARM: begin
        if (!any) begin
          state_d = IDLE;
        end else if (enc != cand_q) begin
          cand_d = enc;
          cnt_d  = cnt_t'(1);
        end else if (cnt_q == DEB_C) begin
          state_d  = PRESS;
          code_d   = cand_q;
          strobe_d = 1'b1;
          held_d   = 1'b1;
          rcnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESS: begin
        // Other keys arriving while held are ignored until a full release.
        if (!any) begin
          state_d = REL;
          cnt_d   = cnt_t'(1);
        end else if (RPT_EN != 0) begin
          if (rcnt_q + 8'd1 == RPT_DELAY_C) begin
            strobe_d = 1'b1;
            rcnt_d   = RPT_RELOAD_C;
          end else begin
            rcnt_d = rcnt_q + 8'd1;
          end
        end
      end
      REL: begin
        // A bounce back to pressed resumes the hold; repeat timing is kept.
        if (any) begin
          state_d = PRESS;
        end else if (cnt_q == DEB_C) begin
          state_d = IDLE;
          held_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    step_d = strobe_d && (code_d == 5'd0);
    clr_d  = strobe_d && (code_d == 5'd1);
  end

  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      rcnt_q   <= '0;
      code_q   <= '0;
      strobe_q <= 1'b0;
      held_q   <= 1'b0;
      step_q   <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      rcnt_q   <= rcnt_d;
      code_q   <= code_d;
      strobe_q <= strobe_d;
      held_q   <= held_d;
      step_q   <= step_d;
      clr_q    <= clr_d;
    end
  end

  assign bus.code   = code_q;
  assign bus.strobe = strobe_q;
  assign bus.held   = held_q;
  assign bus.step   = step_q;
  assign bus.clr    = clr_q;

endmodule
